fp_multiplier_param: RTL and testbench
======================================

Name: fp_multiplier_param

Overview:
- Parametrised IEEE-754 binary floating-point multiplier: successor to the fixed single-precision fmultiplier.
- Generic exponent/mantissa widths, valid/ready handshakes on input and output, round-to-nearest-even, and full special-case handling.
- Multi-cycle FSM datapath sitting between operand producers (register file/FIFO) and result consumers in the FP unit.

Parameters:
- EXP_W, 8, exponent field width (8 = binary32, 11 = binary64, 5 = binary16)
- MAN_W, 23, stored fraction width (hidden bit excluded)
- Derived, not overridable: W = 1+EXP_W+MAN_W; BIAS = 2^(EXP_W-1)-1

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-low
- in_valid  in  1  operands a/b valid
- in_ready  out  1  block can accept operands
- a  in  W  operand A
- b  in  W  operand B
- out_valid  out  1  result z valid
- out_ready  in  1  consumer accepts z
- z  out  W  product

Behaviour:
- Reset (rst low, async): state=IDLE, in_ready=0 during reset then 1 in IDLE, out_valid=0, z=0; all internal regs 0.
- Accept: in_valid&&in_ready at rising edge latches a,b; in_ready=(state==IDLE) only.
- FSM: IDLE -> UNPACK -> MULT -> NORM -> ROUND -> OUT -> IDLE.
  - Each non-OUT state takes 1 cycle.
  - out_valid rises 5 cycles after the accept edge and holds until out_valid&&out_ready; z stable while out_valid=1.
  - Return to IDLE after the output handshake; no overlap, throughput 1 op per >=6 cycles.
- UNPACK: split sign/exp/fraction; sign_z=sa^sb; classify zero/inf/NaN; subnormal inputs flushed to signed zero (FTZ).
- MULT: (MAN_W+1)x(MAN_W+1) unsigned product, 2*MAN_W+2 bits; exponent sum ea+eb-BIAS in EXP_W+2-bit signed.
- NORM: if product MSB set, shift right 1 and exp+1.
- ROUND: RNE using guard, round and sticky (OR of remaining low bits). A mantissa carry-out renormalises and increments exp.
- Exponent rules: result exp >= 2^EXP_W-1 -> signed inf. Result exp <= 0 -> signed zero (FTZ output).
- Special precedence: NaN in either -> canonical qNaN (sign 0, exp all-ones, fraction MSB 1, rest 0); inf*0 -> qNaN; inf*finite -> signed inf; zero*finite -> signed zero.
- Specials still traverse the full FSM; latency is uniform.
- in_valid while busy: ignored (in_ready=0). out_ready high before out_valid: no effect.
- Reset mid-operation aborts immediately; no result is emitted after release.

Optional Feature:
- FMUL_FLAGS_EN defined: extra port flags out 5 {invalid, divzero(always 0), overflow, underflow, inexact}. Registered with z, valid with out_valid, reset 0.
  - inexact=1 when any of guard/round/sticky is nonzero or overflow/underflow occurred.
- Undefined: port absent; no flag logic.

Decomposition:
- Package fp_pkg:
  - FSM state enum
  - special-class enum (ZERO, NORMAL, INF, NAN)
  - flag-index constants
  - function for canonical qNaN pattern given EXP_W/MAN_W
- Sub-module fp_round_rne (combinational): mantissa+G/R/S -> rounded mantissa, carry-out, inexact. Reused by the planned adder.

Test Plan:
- Binary32 defaults: a=b=32'h3E99999A (0.3), out_ready=1 -> z=32'h3DB851EC exactly 5 cycles after accept; in_ready=0 throughout.
- a=32'h40000000 (2.0), b=32'h40400000 (3.0) -> 32'h40C00000; a=32'hBFC00000 (-1.5), b=2.0 -> 32'hC0400000.
- Specials:
  - 32'h7F800000 * 0 -> 32'h7FC00000 (invalid=1 with FMUL_FLAGS_EN)
  - 32'h7F000000 * 32'h7F000000 -> 32'h7F800000 (overflow=1)
  - 32'h00800000 * 32'h00800000 -> 32'h00000000 (underflow=1)
- Backpressure: out_ready=0 for 10 cycles -> out_valid and z held constant; a second in_valid is refused; the op completes after out_ready=1, then in_ready returns high the next cycle.
- Reset mid-op: drop rst 2 cycles after accept -> out_valid=0, z=0 immediately; after release no stale result appears.
- Binary16 instance (EXP_W=5, MAN_W=10): 16'h3C00 * 16'h4000 -> 16'h4000; 16'h7BFF * 16'h4000 -> 16'h7C00.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point unit datapaths.
//   fsm_state_e  : multi-cycle operation sequencer states
//   fp_class_e   : operand / result special-value class
//   FLAG_*       : bit positions inside the exception flag vector
//   qnan_pattern : canonical quiet-NaN encoding for a given format,
//                  returned right-aligned in a 64-bit container
package fp_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_UNPACK = 3'd1,
    S_MULT   = 3'd2,
    S_NORM   = 3'd3,
    S_ROUND  = 3'd4,
    S_OUT    = 3'd5
  } fsm_state_e;

  typedef enum logic [1:0] {
    CLS_ZERO   = 2'd0,
    CLS_NORMAL = 2'd1,
    CLS_INF    = 2'd2,
    CLS_NAN    = 2'd3
  } fp_class_e;

  // flags = {invalid, divzero, overflow, underflow, inexact}
  localparam int unsigned FLAG_W         = 5;
  localparam int unsigned FLAG_INVALID   = 4;
  localparam int unsigned FLAG_DIVZERO   = 3;
  localparam int unsigned FLAG_OVERFLOW  = 2;
  localparam int unsigned FLAG_UNDERFLOW = 1;
  localparam int unsigned FLAG_INEXACT   = 0;

  // Sign 0, exponent all ones, fraction MSB set, remaining fraction bits 0.
  function automatic logic [63:0] qnan_pattern(input int unsigned exp_w,
                                               input int unsigned man_w);
    logic [63:0] p;
    p = '0;
    for (int unsigned i = 0; i < exp_w; i++) begin
      p = p | (64'd1 << (man_w + i));
    end
    p = p | (64'd1 << (man_w - 1));
    return p;
  endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Combinational round-to-nearest-even step.
//   mant_i    : mantissa to be rounded (hidden bit included)
//   guard_i   : first bit below the mantissa LSB
//   round_i   : second bit below the mantissa LSB
//   sticky_i  : OR of every remaining lower bit
//   mant_o    : rounded mantissa
//   carry_o   : rounding overflowed the mantissa (all ones + 1)
//   inexact_o : any discarded bit was nonzero
module fp_round_rne #(
  parameter int unsigned WIDTH = 24
) (
  input  logic [WIDTH-1:0] mant_i,
  input  logic             guard_i,
  input  logic             round_i,
  input  logic             sticky_i,
  output logic [WIDTH-1:0] mant_o,
  output logic             carry_o,
  output logic             inexact_o
);

  logic round_up;

  always_comb begin
    // Above half rounds up; exactly half rounds up only when the LSB is odd.
    round_up          = guard_i & (round_i | sticky_i | mant_i[0]);
    {carry_o, mant_o} = {1'b0, mant_i} + {{WIDTH{1'b0}}, round_up};
    inexact_o         = guard_i | round_i | sticky_i;
  end

endmodule

// File: rtl/fp_multiplier_param.sv
// Parametrised IEEE-754 binary multiplier, multi-cycle, valid/ready on both
// sides. Round-to-nearest-even, subnormal inputs and outputs flushed to zero.
// One operation in flight: IDLE -> UNPACK -> MULT -> NORM -> ROUND -> OUT.
// out_valid rises 5 cycles after the accept edge (OUT packs the result in its
// first cycle, then holds it until out_valid && out_ready).
//   clk       : rising-edge clock
//   rst       : asynchronous active-low reset
//   in_valid  : operands a/b valid
//   in_ready  : block can accept operands (IDLE only)
//   a, b      : operands, 1+EXP_W+MAN_W bits
//   out_valid : result z valid
//   out_ready : consumer accepts z
//   z         : product
//   flags     : {invalid, divzero, overflow, underflow, inexact}, present only
//               when FMUL_FLAGS_EN is defined
module fp_multiplier_param
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   z
`ifdef FMUL_FLAGS_EN
  ,
  output logic [FLAG_W-1:0]      flags
`endif
);

  localparam int unsigned W  = 1 + EXP_W + MAN_W;
  localparam int unsigned PW = 2 * MAN_W + 2;

  typedef logic signed [EXP_W+1:0] sexp_t;

  localparam sexp_t            BIAS      = sexp_t'(2 ** (EXP_W - 1) - 1);
  localparam sexp_t            EXP_MAX   = sexp_t'(2 ** EXP_W - 1);
  localparam logic [EXP_W-1:0] EXP_ONES  = '1;
  localparam logic [63:0]      QNAN_WIDE = qnan_pattern(EXP_W, MAN_W);
  localparam logic [W-1:0]     QNAN      = QNAN_WIDE[W-1:0];

  function automatic fp_class_e classify(input logic [EXP_W-1:0] e,
                                         input logic [MAN_W-1:0] f);
    if (e == EXP_ONES) return (f != '0) ? CLS_NAN : CLS_INF;
    if (e == '0)       return CLS_ZERO;  // subnormals flushed here
    return CLS_NORMAL;
  endfunction

  fsm_state_e       state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     z_q, z_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic             sign_q, sign_d;
  fp_class_e        cls_q, cls_d;
  logic [EXP_W-1:0] ea_q, ea_d;
  logic [EXP_W-1:0] eb_q, eb_d;
  logic [MAN_W:0]   ma_q, ma_d;
  logic [MAN_W:0]   mb_q, mb_d;
  logic [PW-1:0]    prod_q, prod_d;
  sexp_t            exp_q, exp_d;
  logic [MAN_W-1:0] frac_q, frac_d;
`ifdef FMUL_FLAGS_EN
  logic             invalid_q, invalid_d;
  logic             inexact_q, inexact_d;
  logic [FLAG_W-1:0] flags_q, flags_d;
`endif

  fp_class_e        cls_a, cls_b;
  logic             snan_a, snan_b;
  logic [MAN_W:0]   rnd_mant;
  logic             rnd_carry;
  logic             rnd_inexact;

  assign cls_a  = classify(a_q[W-2:MAN_W], a_q[MAN_W-1:0]);
  assign cls_b  = classify(b_q[W-2:MAN_W], b_q[MAN_W-1:0]);
  assign snan_a = (cls_a == CLS_NAN) && !a_q[MAN_W-1];
  assign snan_b = (cls_b == CLS_NAN) && !b_q[MAN_W-1];

  // NORM left-aligns the product instead of shifting it right, so the bits
  // below the kept mantissa stay available for guard/round/sticky.
  fp_round_rne #(
    .WIDTH(MAN_W + 1)
  ) u_round (
    .mant_i   (prod_q[PW-1:MAN_W+1]),
    .guard_i  (prod_q[MAN_W]),
    .round_i  (prod_q[MAN_W-1]),
    .sticky_i (|prod_q[MAN_W-2:0]),
    .mant_o   (rnd_mant),
    .carry_o  (rnd_carry),
    .inexact_o(rnd_inexact)
  );

  // On a rounding carry the mantissa wraps to all zeros, which is already
  // the correct fraction after renormalisation; only the exponent moves.
`ifdef FMUL_FLAGS_EN
  logic unused_hidden;
  assign unused_hidden = rnd_mant[MAN_W];
`else
  logic [1:0] unused_round;
  assign unused_round = {rnd_mant[MAN_W], rnd_inexact};
`endif

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    z_d         = z_q;
    a_d         = a_q;
    b_d         = b_q;
    sign_d      = sign_q;
    cls_d       = cls_q;
    ea_d        = ea_q;
    eb_d        = eb_q;
    ma_d        = ma_q;
    mb_d        = mb_q;
    prod_d      = prod_q;
    exp_d       = exp_q;
    frac_d      = frac_q;
`ifdef FMUL_FLAGS_EN
    invalid_d   = invalid_q;
    inexact_d   = inexact_q;
    flags_d     = flags_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d     = a;
          b_d     = b;
          state_d = S_UNPACK;
        end
      end

      S_UNPACK: begin
        sign_d = a_q[W-1] ^ b_q[W-1];
        ea_d   = a_q[W-2:MAN_W];
        eb_d   = b_q[W-2:MAN_W];
        ma_d   = {1'b1, a_q[MAN_W-1:0]};
        mb_d   = {1'b1, b_q[MAN_W-1:0]};
`ifdef FMUL_FLAGS_EN
        invalid_d = 1'b0;
`endif
        if (cls_a == CLS_NAN || cls_b == CLS_NAN) begin
          cls_d = CLS_NAN;
`ifdef FMUL_FLAGS_EN
          invalid_d = snan_a | snan_b;
`endif
        end else if ((cls_a == CLS_INF && cls_b == CLS_ZERO) ||
                     (cls_a == CLS_ZERO && cls_b == CLS_INF)) begin
          cls_d = CLS_NAN;
`ifdef FMUL_FLAGS_EN
          invalid_d = 1'b1;
`endif
        end else if (cls_a == CLS_INF || cls_b == CLS_INF) begin
          cls_d = CLS_INF;
        end else if (cls_a == CLS_ZERO || cls_b == CLS_ZERO) begin
          cls_d = CLS_ZERO;
        end else begin
          cls_d = CLS_NORMAL;
        end
        state_d = S_MULT;
      end

      S_MULT: begin
        prod_d  = PW'(ma_q) * PW'(mb_q);
        exp_d   = sexp_t'({2'b00, ea_q}) + sexp_t'({2'b00, eb_q}) - BIAS;
        state_d = S_NORM;
      end

      S_NORM: begin
        if (prod_q[PW-1]) exp_d  = exp_q + sexp_t'(1);
        else              prod_d = prod_q << 1;
        state_d = S_ROUND;
      end

      S_ROUND: begin
        frac_d  = rnd_mant[MAN_W-1:0];
        exp_d   = exp_q + (rnd_carry ? sexp_t'(1) : sexp_t'(0));
`ifdef FMUL_FLAGS_EN
        inexact_d = rnd_inexact;
`endif
        state_d = S_OUT;
      end

      S_OUT: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
`ifdef FMUL_FLAGS_EN
          flags_d = '0;
`endif
          unique case (cls_q)
            CLS_NAN: begin
              z_d = QNAN;
`ifdef FMUL_FLAGS_EN
              flags_d[FLAG_INVALID] = invalid_q;
`endif
            end
            CLS_INF:  z_d = {sign_q, EXP_ONES, {MAN_W{1'b0}}};
            CLS_ZERO: z_d = {sign_q, {(W-1){1'b0}}};
            default: begin
              if (exp_q >= EXP_MAX) begin
                z_d = {sign_q, EXP_ONES, {MAN_W{1'b0}}};
`ifdef FMUL_FLAGS_EN
                flags_d[FLAG_OVERFLOW] = 1'b1;
                flags_d[FLAG_INEXACT]  = 1'b1;
`endif
              end else if (exp_q <= sexp_t'(0)) begin
                z_d = {sign_q, {(W-1){1'b0}}};
`ifdef FMUL_FLAGS_EN
                flags_d[FLAG_UNDERFLOW] = 1'b1;
                flags_d[FLAG_INEXACT]   = 1'b1;
`endif
              end else begin
                z_d = {sign_q, exp_q[EXP_W-1:0], frac_q};
`ifdef FMUL_FLAGS_EN
                flags_d[FLAG_INEXACT] = inexact_q;
`endif
              end
            end
          endcase
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      z_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sign_q      <= 1'b0;
      cls_q       <= CLS_ZERO;
      ea_q        <= '0;
      eb_q        <= '0;
      ma_q        <= '0;
      mb_q        <= '0;
      prod_q      <= '0;
      exp_q       <= '0;
      frac_q      <= '0;
`ifdef FMUL_FLAGS_EN
      invalid_q   <= 1'b0;
      inexact_q   <= 1'b0;
      flags_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      z_q         <= z_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sign_q      <= sign_d;
      cls_q       <= cls_d;
      ea_q        <= ea_d;
      eb_q        <= eb_d;
      ma_q        <= ma_d;
      mb_q        <= mb_d;
      prod_q      <= prod_d;
      exp_q       <= exp_d;
      frac_q      <= frac_d;
`ifdef FMUL_FLAGS_EN
      invalid_q   <= invalid_d;
      inexact_q   <= inexact_d;
      flags_q     <= flags_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign z         = z_q;
`ifdef FMUL_FLAGS_EN
  assign flags     = flags_q;
`endif

endmodule

// File: tb/tb_fp_multiplier_param.sv
module tb_fp_multiplier_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, z;
  logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
  logic [15:0] h_a, h_b, h_z;
`ifdef FMUL_FLAGS_EN
  logic [4:0]  flags, h_flags;
`endif

  always #5 clk = ~clk;

  fp_multiplier_param dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .z        (z)
`ifdef FMUL_FLAGS_EN
    ,
    .flags    (flags)
`endif
  );

  fp_multiplier_param #(
    .EXP_W(5),
    .MAN_W(10)
  ) dut16 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (h_in_valid),
    .in_ready (h_in_ready),
    .a        (h_a),
    .b        (h_b),
    .out_valid(h_out_valid),
    .out_ready(h_out_ready),
    .z        (h_z)
`ifdef FMUL_FLAGS_EN
    ,
    .flags    (h_flags)
`endif
  );

  typedef struct packed {
    logic [31:0] z;
    logic [4:0]  fl;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] z;
    logic [4:0]  fl;
  } vec_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned tests = 0;
  int unsigned fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Scoreboard: every handshake seen on the binary32 output pops one expectation.
  always @(negedge clk) begin
    if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: got z=%h with no operation outstanding", z);
      end else begin
        mon_e = sb.pop_front();
        check("z", z, mon_e.z);
`ifdef FMUL_FLAGS_EN
        check("flags", 32'(flags), 32'(mon_e.fl));
`endif
      end
    end
  end

  // Called at posedge+2; returns at accept-edge+2.
  task automatic send(input logic [31:0] av, input logic [31:0] bv,
                      input exp_t e, input bit track);
    int unsigned n = 0;
    while (in_ready !== 1'b1 && n < 40) begin
      @(posedge clk); #2;
      n++;
    end
    if (in_ready !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
      return;
    end
    a = av; b = bv; in_valid = 1'b1;
    @(posedge clk);
    if (track) sb.push_back(e);
    #2 in_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(posedge clk); #2;
      n++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic send16(input string name, input logic [15:0] av, input logic [15:0] bv,
                        input logic [15:0] zr, input logic [4:0] flr);
    int unsigned n = 0;
    while (h_in_ready !== 1'b1 && n < 40) begin
      @(posedge clk); #2;
      n++;
    end
    h_a = av; h_b = bv; h_in_valid = 1'b1;
    @(posedge clk); #2;
    h_in_valid = 1'b0;
    n = 0;
    while (h_out_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #2;
      n++;
    end
    check({name, "_valid"}, 32'(h_out_valid), 32'd1);
    check(name, 32'(h_z), 32'(zr));
`ifdef FMUL_FLAGS_EN
    check({name, "_flags"}, 32'(h_flags), 32'(flr));
`else
    if (flr === 5'bx) $display("note: unknown flag expectation");
`endif
    @(posedge clk); #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

  vec_t        vecs[20];
  int unsigned lat, rdy, bad, bad_rdy, stale;

  initial begin
    vecs[0]  = '{32'h40000000, 32'h40400000, 32'h40C00000, 5'b00000};
    vecs[1]  = '{32'hBFC00000, 32'h40000000, 32'hC0400000, 5'b00000};
    vecs[2]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 5'b10000};
    vecs[3]  = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 5'b00101};
    vecs[4]  = '{32'h00800000, 32'h00800000, 32'h00000000, 5'b00011};
    vecs[5]  = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 5'b00000};
    vecs[6]  = '{32'hC0000000, 32'hC0400000, 32'h40C00000, 5'b00000};
    vecs[7]  = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 5'b00000};
    vecs[8]  = '{32'h7F800001, 32'h3F800000, 32'h7FC00000, 5'b10000};
    vecs[9]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 5'b00000};
    vecs[10] = '{32'h80000000, 32'h40400000, 32'h80000000, 5'b00000};
    vecs[11] = '{32'h00000001, 32'h3F800000, 32'h00000000, 5'b00000};
    vecs[12] = '{32'h3FC00000, 32'h3F800001, 32'h3FC00002, 5'b00001};
    vecs[13] = '{32'h3FC00000, 32'h3F800003, 32'h3FC00004, 5'b00001};
    vecs[14] = '{32'h3F800001, 32'h3FFFFFFE, 32'h40000000, 5'b00001};
    vecs[15] = '{32'h00000000, 32'h7F800000, 32'h7FC00000, 5'b10000};
    vecs[16] = '{32'h7F000000, 32'h3F800000, 32'h7F000000, 5'b00000};
    vecs[17] = '{32'h00800000, 32'h3F800000, 32'h00800000, 5'b00000};
    vecs[18] = '{32'h00800000, 32'h3F000000, 32'h00000000, 5'b00011};
    vecs[19] = '{32'h7F000000, 32'h40000000, 32'h7F800000, 5'b00101};

    rst = 1'b0; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    h_in_valid = 1'b0; h_a = '0; h_b = '0; h_out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #2;
    check("reset_in_ready", 32'(in_ready), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_z", z, 32'd0);
    rst = 1'b1;
    @(posedge clk); #2;
    check("idle_in_ready", 32'(in_ready), 32'd1);

    // Latency: result visible 5 edges after accept, in_ready low meanwhile.
    send(32'h3E99999A, 32'h3E99999A, '{32'h3DB851EC, 5'b00001}, 1'b1);
    lat = 0; rdy = 0;
    while (lat < 20) begin
      @(posedge clk); #2;
      lat++;
      if (in_ready === 1'b1) rdy++;
      if (out_valid === 1'b1) break;
    end
    check("latency", lat, 32'd5);
    check("busy_in_ready", rdy, 32'd0);
    drain();

    for (int i = 0; i < 20; i++) begin
      send(vecs[i].a, vecs[i].b, '{vecs[i].z, vecs[i].fl}, 1'b1);
      drain();
    end

    // Backpressure: result held, second operand refused.
    out_ready = 1'b0;
    send(32'h40000000, 32'h40400000, '{32'h40C00000, 5'b00000}, 1'b1);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #2;
      lat++;
    end
    bad = 0; bad_rdy = 0;
    repeat (10) begin
      @(posedge clk); #2;
      if (out_valid !== 1'b1 || z !== 32'h40C00000) bad++;
      if (in_ready !== 1'b0) bad_rdy++;
      in_valid = 1'b1; a = 32'h3F800000; b = 32'h3F800000;
    end
    check("bp_hold", bad, 32'd0);
    check("bp_refuse", bad_rdy, 32'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #2;
    check("bp_ready_after", 32'(in_ready), 32'd1);
    check("bp_valid_after", 32'(out_valid), 32'd0);
    drain();

    // Reset two cycles into an operation.
    send(32'h40000000, 32'h40400000, '{32'h0, 5'b0}, 1'b0);
    @(posedge clk);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_z", z, 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    stale = 0;
    repeat (12) begin
      @(posedge clk); #2;
      if (out_valid !== 1'b0) stale++;
    end
    check("no_stale", stale, 32'd0);
    check("rst_in_ready_after", 32'(in_ready), 32'd1);

    send16("h_one_two", 16'h3C00, 16'h4000, 16'h4000, 5'b00000);
    send16("h_overflow", 16'h7BFF, 16'h4000, 16'h7C00, 5'b00101);

    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
